// File: rtl/int2flt_seq.sv
// int2flt_seq -- multi-cycle signed integer to floating-point converter.
//
// Converts a two's-complement INT_W-bit integer into a {sign, biased
// exponent, mantissa} float (hidden leading 1). It uses one normalising
// shift per cycle, so latency depends on the operand's leading-zero count.
//
// Optional feature macro: INT2FLT_ROUND_EN
//   defined   -> round-to-nearest-even on the bits dropped below the mantissa
//   undefined -> truncation (guard/sticky ignored, no carry path)
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous, active-low reset
//   start    in   conversion request, honoured only while idle
//   int_in   in   [INT_W-1:0] signed operand, captured when start is accepted
//   busy     out  high whenever a conversion is in flight (any state but IDLE)
//   done     out  one-cycle pulse: flt_out holds a fresh result
//   flt_out  out  [EXP_W+MAN_W:0] {sign, exponent, mantissa}, held between results
module int2flt_seq #(
  parameter int INT_W = 16,
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [INT_W-1:0]   int_in,
  output logic               busy,
  output logic               done,
  output logic [EXP_W+MAN_W:0] flt_out
);

  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(INT_W - 1 + BIAS);

  // The largest reachable exponent must stay below the all-ones (inf/NaN)
  // code. A rounding carry can only occur for magnitudes below 2^(INT_W-1),
  // so the largest reachable exponent is exactly INT_W-1+bias.
  generate
    if (INT_W + BIAS > (1 << EXP_W) - 1) begin : g_bad_params
      $error("int2flt_seq: INT_W=%0d cannot be represented finitely with EXP_W=%0d",
             INT_W, EXP_W);
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, ABS, NORM, ROUND, DONE} state_t;

  state_t             state_reg;
  logic [INT_W-1:0]   int_reg;
  logic               sign_reg;
  logic [INT_W-1:0]   mag_reg;
  logic [EXP_W-1:0]   exp_reg;

  // Mantissa field taken from below the leading 1 (which sits at the MSB
  // once NORM has finished).
  logic [MAN_W-1:0]   man_trunc;
`ifdef INT2FLT_ROUND_EN
  logic               guard_bit;
  logic               sticky_bit;
`endif

  generate
    if (MAN_W >= INT_W - 1) begin : g_pad
      // Every significant bit fits: left-align and zero-fill, nothing to round.
      assign man_trunc = MAN_W'(mag_reg[INT_W-2:0]) << (MAN_W - INT_W + 1);
`ifdef INT2FLT_ROUND_EN
      assign guard_bit  = 1'b0;
      assign sticky_bit = 1'b0;
`endif
    end else begin : g_cut
      assign man_trunc = mag_reg[INT_W-2 -: MAN_W];
`ifdef INT2FLT_ROUND_EN
      assign guard_bit = mag_reg[INT_W-2-MAN_W];
      if (INT_W - 2 - MAN_W > 0) begin : g_sticky
        assign sticky_bit = |mag_reg[INT_W-3-MAN_W:0];
      end else begin : g_no_sticky
        assign sticky_bit = 1'b0;
      end
`endif
    end
  endgenerate

  logic [MAN_W-1:0]   man_final;
  logic [EXP_W-1:0]   exp_final;

`ifdef INT2FLT_ROUND_EN
  logic [MAN_W:0]     man_sum;
  // Round up on guard when above half (sticky) or at a tie with an odd LSB.
  // A carry out leaves the low MAN_W bits at zero, which is the cleared
  // mantissa; the exponent absorbs the carry.
  assign man_sum   = {1'b0, man_trunc}
                   + {{MAN_W{1'b0}}, guard_bit & (sticky_bit | man_trunc[0])};
  assign man_final = man_sum[MAN_W-1:0];
  assign exp_final = exp_reg + {{(EXP_W-1){1'b0}}, man_sum[MAN_W]};
`else
  assign man_final = man_trunc;
  assign exp_final = exp_reg;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      int_reg   <= '0;
      sign_reg  <= 1'b0;
      mag_reg   <= '0;
      exp_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      flt_out   <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            int_reg   <= int_in;
            busy      <= 1'b1;
            state_reg <= ABS;
          end
        end
        ABS: begin
          sign_reg <= int_reg[INT_W-1];
          // Negating in INT_W bits maps the most negative value onto
          // 2^(INT_W-1), which is exactly its magnitude as unsigned.
          mag_reg  <= int_reg[INT_W-1] ? -int_reg : int_reg;
          exp_reg  <= EXP_TOP;
          if (int_reg == '0) begin
            flt_out   <= '0;
            done      <= 1'b1;
            state_reg <= DONE;
          end else begin
            state_reg <= NORM;
          end
        end
        NORM: begin
          if (mag_reg[INT_W-1]) begin
            state_reg <= ROUND;
          end else begin
            mag_reg <= mag_reg << 1;
            exp_reg <= exp_reg - 1'b1;
          end
        end
        ROUND: begin
          flt_out   <= {sign_reg, exp_final, man_final};
          done      <= 1'b1;
          state_reg <= DONE;
        end
        DONE: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int2flt_seq.sv
// Self-checking bench for int2flt_seq at default parameters.
// Latency is the number of clock edges from the accepting edge up to and
// including the first edge that sees done high.
module tb_int2flt_seq;

  localparam int INT_W = 16;
  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] int_in;
  logic        busy;
  logic        done;
  logic [15:0] flt_out;

  int n_checks = 0;
  int n_fail   = 0;

  int2flt_seq #(.INT_W(INT_W), .EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .int_in  (int_in),
    .busy    (busy),
    .done    (done),
    .flt_out (flt_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] din;
    logic [15:0] flt;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: find the leading-one position arithmetically, scale the
  // fractional remainder into the mantissa field, round on the remainder.
  function automatic void model(input logic [15:0] v, output logic [15:0] f, output int lat);
    int m, p, e, man, sh;
    bit s;
`ifdef INT2FLT_ROUND_EN
    int rem, half;
`endif
    s = v[15];
    m = s ? 65536 - int'(v) : int'(v);
    if (m == 0) begin
      f   = 16'h0000;
      lat = 2;
      return;
    end
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    e = p + BIAS;
    if (p <= MAN_W) begin
      man = (m - (1 << p)) << (MAN_W - p);
    end else begin
      sh  = p - MAN_W;
      man = (m >> sh) - (1 << MAN_W);
`ifdef INT2FLT_ROUND_EN
      rem  = m % (1 << sh);
      half = 1 << (sh - 1);
      if (rem > half || (rem == half && (man % 2) == 1)) man++;
`endif
      if (man == (1 << MAN_W)) begin
        man = 0;
        e++;
      end
    end
    f   = {s, 5'(e), 10'(man)};
    lat = (INT_W - 1 - p) + 4;
  endfunction

  // One conversion from idle; lat = -1 if done never arrives.
  task automatic run(input logic [15:0] v, output logic [15:0] res, output int lat);
    @(negedge clk);
    int_in = v;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    check("busy_after_accept", {31'b0, busy}, 32'd1);
    lat = -1;
    res = 16'hxxxx;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = n + 1;
        res = flt_out;
        break;
      end
    end
    $display("conv in=%h out=%h lat=%0d", v, res, lat);
  endtask

  logic [15:0] got, exp_f;
  int          got_lat, exp_lat, ndone;
  logic [15:0] rv;

  initial begin
    vecs[0] = '{16'h0000, 16'h0000, 2};
    vecs[1] = '{16'h8000, 16'hF800, 4};
    vecs[2] = '{16'h0001, 16'h3C00, 19};
    vecs[3] = '{16'hFFFF, 16'hBC00, 19};
`ifdef INT2FLT_ROUND_EN
    vecs[4] = '{16'h7FFF, 16'h7800, 5};
    vecs[6] = '{16'h0803, 16'h6802, 8};
`else
    vecs[4] = '{16'h7FFF, 16'h77FF, 5};
    vecs[6] = '{16'h0803, 16'h6801, 8};
`endif
    vecs[5] = '{16'h0801, 16'h6800, 8};
    vecs[7] = '{16'h0003, 16'h4200, 18};

    // Reset state
    rst    = 1'b0;
    start  = 1'b0;
    int_in = 16'h0000;
    #3;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_flt",  {16'b0, flt_out}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      run(vecs[i].din, got, got_lat);
      check("vec_flt", {16'b0, got}, {16'b0, vecs[i].flt});
      check("vec_lat", got_lat, vecs[i].lat);
    end

    // Randomised operands spanning all leading-zero counts
    for (int i = 0; i < 40; i++) begin
      rv = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) rv = -rv;
      model(rv, exp_f, exp_lat);
      run(rv, got, got_lat);
      check("rand_flt", {16'b0, got}, {16'b0, exp_f});
      check("rand_lat", got_lat, exp_lat);
    end

    // start while busy and in the DONE cycle must both be ignored
    @(negedge clk);
    int_in = 16'h0803;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    int_in = 16'h0001;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    ndone  = 0;
    got    = 16'h0000;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        got   = flt_out;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    model(16'h0803, exp_f, exp_lat);
    $display("conv in=0803 (restart ignored) out=%h pulses=%0d", got, ndone);
    check("busy_start_pulses", ndone, 1);
    check("busy_start_flt", {16'b0, got}, {16'b0, exp_f});
    check("busy_start_held", {16'b0, flt_out}, {16'b0, exp_f});
    check("busy_start_idle", {31'b0, busy}, 32'd0);

    // Reset asserted mid-NORM aborts the conversion
    @(negedge clk);
    int_in = 16'h0001;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_flt",  {16'b0, flt_out}, 32'd0);
    @(negedge clk);
    rst   = 1'b1;
    ndone = 0;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    $display("abort in=0001 pulses=%0d", ndone);
    check("abort_no_done", ndone, 0);
    run(16'h0003, got, got_lat);
    check("post_reset_flt", {16'b0, got}, 32'h0000_4200);
    check("post_reset_lat", got_lat, 18);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
